// File: rtl/sc_mseq_pkg.sv
// Shared definitions for the ARC microprogram sequencer: mode select encoding
// and the opcode format that selects the masked branch/sethi decode.
package sc_mseq_pkg;

  typedef enum logic [2:0] {
    MSEQ_NEXT   = 3'b000,
    MSEQ_JUMP   = 3'b001,
    MSEQ_DECODE = 3'b010,
    MSEQ_COND   = 3'b011,
    MSEQ_CALL   = 3'b100,
    MSEQ_RET    = 3'b101
  } mseq_mode_e;

  localparam logic [1:0] MSEQ_FMT_BRANCH = 2'b00;

endpackage

// File: rtl/sc_mseq_stack.sv
// Return-address LIFO for the microprogram sequencer. Pointer runs 0..STACK_DEPTH;
// pushes at full and pops at empty are dropped and reported on one-cycle strobes.
module sc_mseq_stack #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned DATAWIDTH   = 11
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 stallN,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATAWIDTH-1:0] data,
  output logic [DATAWIDTH-1:0] top,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int unsigned PW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [DATAWIDTH-1:0] mem [STACK_DEPTH];
  logic [PW-1:0]        ptr;
  logic [AW-1:0]        wrIdx;
  logic [AW-1:0]        topIdx;

  assign empty  = (ptr == '0);
  assign full   = (ptr == PW'(STACK_DEPTH));
  assign wrIdx  = AW'(ptr);
  assign topIdx = AW'(ptr - 1'b1);
  assign top    = mem[topIdx];

  assign overflow  = stallN & push & full;
  assign underflow = stallN & pop & empty;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      ptr <= '0;
    end else if (stallN) begin
      if (push && !full) begin
        mem[wrIdx] <= data;
        ptr        <= ptr + 1'b1;
      end else if (pop && !empty) begin
        ptr <= ptr - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_micro_sequencer.sv
// Microprogram sequencer: owns the uPC and selects the next control-store address
// from increment, jump, conditional jump, opcode decode and call/return.
module sc_micro_sequencer
  import sc_mseq_pkg::*;
#(
  parameter int unsigned DATAWIDTH_ADDR   = 11,
  parameter int unsigned DATAWIDTH_DECODE = 8,
  parameter int unsigned DATAWIDTH_SEL    = 3,
  parameter int unsigned STACK_DEPTH      = 4
) (
  input  logic                        SC_MSEQ_CLOCK_50,
  input  logic                        SC_MSEQ_RESET_InLow,
  input  logic                        SC_MSEQ_Stall_InLow,
  input  logic [DATAWIDTH_SEL-1:0]    SC_MSEQ_Sel_InBUS,
  input  logic                        SC_MSEQ_Cond_In,
  input  logic [DATAWIDTH_ADDR-1:0]   SC_MSEQ_Jump_InBUS,
  input  logic [DATAWIDTH_DECODE-1:0] SC_MSEQ_Decode_InBUS,
  output logic [DATAWIDTH_ADDR-1:0]   SC_MSEQ_uPC_OutBUS,
  output logic [DATAWIDTH_ADDR-1:0]   SC_MSEQ_NextAddr_OutBUS,
  output logic                        SC_MSEQ_StackEmpty_Out,
  output logic                        SC_MSEQ_StackFull_Out,
  output logic                        SC_MSEQ_Error_Out
);

  mseq_mode_e                  mode;
  logic [DATAWIDTH_ADDR-1:0]   uPC;
  logic [DATAWIDTH_ADDR-1:0]   incAddr;
  logic [DATAWIDTH_ADDR-1:0]   decAddr;
  logic [DATAWIDTH_ADDR-1:0]   nextAddr;
  logic [DATAWIDTH_ADDR-1:0]   stackTop;
  logic                        stackEmpty;
  logic                        stackFull;
  logic                        overflow;
  logic                        underflow;
  logic                        errorReg;
  logic                        push;
  logic                        pop;

  assign mode    = mseq_mode_e'(SC_MSEQ_Sel_InBUS[2:0]);
  assign incAddr = uPC + 1'b1;
  assign push    = (mode == MSEQ_CALL);
  assign pop     = (mode == MSEQ_RET);

  // Branch/sethi opcodes share one microroutine per op2 group, so op3 low bits are masked.
  always_comb begin
    decAddr = '0;
    if (SC_MSEQ_Decode_InBUS[DATAWIDTH_DECODE-1 -: 2] == MSEQ_FMT_BRANCH)
      decAddr = {1'b1, SC_MSEQ_Decode_InBUS[DATAWIDTH_DECODE-1:3], 3'b000, 2'b00};
    else
      decAddr = {1'b1, SC_MSEQ_Decode_InBUS, 2'b00};
  end

  always_comb begin
    nextAddr = incAddr;
    case (mode)
      MSEQ_JUMP:   nextAddr = SC_MSEQ_Jump_InBUS;
      MSEQ_DECODE: nextAddr = decAddr;
      MSEQ_COND:   nextAddr = SC_MSEQ_Cond_In ? SC_MSEQ_Jump_InBUS : incAddr;
      MSEQ_CALL:   nextAddr = SC_MSEQ_Jump_InBUS;
      MSEQ_RET:    nextAddr = stackEmpty ? incAddr : stackTop;
      default:     nextAddr = incAddr;
    endcase
  end

  sc_mseq_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .DATAWIDTH   (DATAWIDTH_ADDR)
  ) uStack (
    .clk       (SC_MSEQ_CLOCK_50),
    .rstN      (SC_MSEQ_RESET_InLow),
    .stallN    (SC_MSEQ_Stall_InLow),
    .push      (push),
    .pop       (pop),
    .data      (incAddr),
    .top       (stackTop),
    .empty     (stackEmpty),
    .full      (stackFull),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_ff @(posedge SC_MSEQ_CLOCK_50) begin
    if (!SC_MSEQ_RESET_InLow) begin
      uPC      <= '0;
      errorReg <= 1'b0;
    end else if (SC_MSEQ_Stall_InLow) begin
      uPC <= nextAddr;
      if (overflow || underflow)
        errorReg <= 1'b1;
    end
  end

  assign SC_MSEQ_uPC_OutBUS      = uPC;
  assign SC_MSEQ_NextAddr_OutBUS = nextAddr;
  assign SC_MSEQ_StackEmpty_Out  = stackEmpty;
  assign SC_MSEQ_StackFull_Out   = stackFull;
  assign SC_MSEQ_Error_Out       = errorReg;

endmodule

// File: tb/tb_sc_micro_sequencer.sv
// Bench for sc_micro_sequencer: directed scenarios then random traffic, all checked
// against an address-arithmetic model with a queue as the return stack.
module tb_sc_micro_sequencer;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstN;
  logic          stallN;
  logic [2:0]    sel;
  logic          cond;
  logic [AW-1:0] jump;
  logic [DW-1:0] dec;
  logic [AW-1:0] uPC;
  logic [AW-1:0] nextAddr;
  logic          sEmpty;
  logic          sFull;
  logic          err;

  int passCount = 0;
  int totalCount = 0;

  int mUpc;
  int mStack[$];
  bit mErr;
  bit mKnown = 0;

  always #5 clk = ~clk;

  sc_micro_sequencer #(
    .DATAWIDTH_ADDR   (AW),
    .DATAWIDTH_DECODE (DW),
    .DATAWIDTH_SEL    (3),
    .STACK_DEPTH      (DEPTH)
  ) dut (
    .SC_MSEQ_CLOCK_50        (clk),
    .SC_MSEQ_RESET_InLow     (rstN),
    .SC_MSEQ_Stall_InLow     (stallN),
    .SC_MSEQ_Sel_InBUS       (sel),
    .SC_MSEQ_Cond_In         (cond),
    .SC_MSEQ_Jump_InBUS      (jump),
    .SC_MSEQ_Decode_InBUS    (dec),
    .SC_MSEQ_uPC_OutBUS      (uPC),
    .SC_MSEQ_NextAddr_OutBUS (nextAddr),
    .SC_MSEQ_StackEmpty_Out  (sEmpty),
    .SC_MSEQ_StackFull_Out   (sFull),
    .SC_MSEQ_Error_Out       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int modelDecode(input int d);
    if ((d >> 6) == 0) return 'h400 + ((d >> 3) << 5);
    return 'h400 + (d << 2);
  endfunction

  function automatic int modelNext(input int s, input bit c, input int j, input int d);
    int inc;
    inc = (mUpc + 1) % (1 << AW);
    case (s)
      1: return j;
      2: return modelDecode(d);
      3: return c ? j : inc;
      4: return j;
      5: return (mStack.size() == 0) ? inc : mStack[$];
      default: return inc;
    endcase
  endfunction

  // One clock: apply inputs, check the combinational address, clock, check state.
  task automatic cyc(input int s, input bit c, input int j, input int d,
                     input bit st = 1'b1, input bit rs = 1'b1);
    int nx;
    int inc;
    sel = 3'(s); cond = c; jump = AW'(j); dec = DW'(d); stallN = st; rstN = rs;
    #1;
    if (mKnown) begin
      nx = modelNext(s, c, j, d);
      chk("nextAddr", 32'(nextAddr), 32'(nx));
    end
    @(posedge clk);
    if (!rs) begin
      mUpc = 0; mStack.delete(); mErr = 0; mKnown = 1;
    end else if (st && mKnown) begin
      inc = (mUpc + 1) % (1 << AW);
      if (s == 4) begin
        if (mStack.size() < DEPTH) mStack.push_back(inc);
        else mErr = 1;
      end else if (s == 5 && mStack.size() == 0) begin
        mErr = 1;
      end else if (s == 5) begin
        void'(mStack.pop_back());
      end
      mUpc = nx;
    end
    #1;
    if (mKnown) begin
      chk("uPC", 32'(uPC), 32'(mUpc));
      chk("stackEmpty", 32'(sEmpty), 32'(mStack.size() == 0));
      chk("stackFull", 32'(sFull), 32'(mStack.size() == DEPTH));
      chk("error", 32'(err), 32'(mErr));
    end
  endtask

  initial begin
    int s;
    rstN = 1'b0; stallN = 1'b1; sel = '0; cond = 1'b0; jump = '0; dec = '0;
    #2;
    cyc(0, 0, 0, 0, 1, 0);
    chk("resetUpc", 32'(uPC), 32'h0);
    chk("resetEmpty", 32'(sEmpty), 32'h1);
    repeat (3) cyc(0, 0, 0, 0);
    chk("countTo3", 32'(uPC), 32'h3);

    cyc(1, 0, 'h7FF, 0);
    cyc(0, 0, 0, 0);
    chk("wrap", 32'(uPC), 32'h0);
    cyc(2, 0, 0, 'h80);
    chk("decode80", 32'(uPC), 32'h600);
    cyc(2, 0, 0, 'h0F);
    chk("decode0F", 32'(uPC), 32'h420);

    cyc(1, 0, 'h010, 0);
    cyc(3, 0, 'h123, 0);
    chk("condFalse", 32'(uPC), 32'h011);
    cyc(3, 1, 'h123, 0);
    chk("condTrue", 32'(uPC), 32'h123);

    cyc(1, 0, 'h005, 0);
    cyc(4, 0, 'h100, 0);
    cyc(4, 0, 'h200, 0);
    cyc(5, 0, 0, 0);
    chk("ret1", 32'(uPC), 32'h101);
    cyc(5, 0, 0, 0);
    chk("ret2", 32'(uPC), 32'h006);
    chk("nestErr", 32'(err), 32'h0);

    for (int i = 0; i < 5; i++) cyc(4, 0, 'h300 + i, 0);
    chk("overflowErr", 32'(err), 32'h1);
    chk("overflowUpc", 32'(uPC), 32'h304);
    chk("overflowFull", 32'(sFull), 32'h1);
    for (int i = 0; i < DEPTH; i++) cyc(5, 0, 0, 0);
    cyc(1, 0, 'h050, 0);
    cyc(5, 0, 0, 0);
    chk("underflowUpc", 32'(uPC), 32'h051);
    chk("underflowErr", 32'(err), 32'h1);

    cyc(0, 0, 0, 0, 1, 0);
    cyc(4, 0, 'h0A0, 0);
    repeat (3) cyc(4, 0, 'h1B0, 0, 0);
    chk("stallUpc", 32'(uPC), 32'h0A0);
    cyc(4, 0, 'h0C0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("midResetUpc", 32'(uPC), 32'h0);
    chk("midResetEmpty", 32'(sEmpty), 32'h1);
    chk("midResetErr", 32'(err), 32'h0);

    for (int i = 0; i < 400; i++) begin
      s = $urandom_range(0, 7);
      if (s == 4 || s == 5) s = ($urandom_range(0, 1) == 0) ? 4 : 5;
      cyc(s, 1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << AW) - 1)),
          int'($urandom_range(0, (1 << DW) - 1)),
          $urandom_range(0, 4) != 0, $urandom_range(0, 49) != 0);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
